// File: rtl/wfq_pkg.sv
// Shared widths, tag entry layout, sorter FSM states and the modular
// finish-time ordering used by the WFQ tag sorter.
package wfq_pkg;

  localparam int FT_W  = 16;
  localparam int FID_W = 13;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic [FT_W-1:0]  ftime;
    logic [FID_W-1:0] flow_id;
    logic [LEN_W-1:0] length;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } sort_state_e;

  // Finish times wrap; a is earlier than b when (a - b) lands in the upper half.
  function automatic logic ft_earlier(input logic [FT_W-1:0] a,
                                      input logic [FT_W-1:0] b);
    logic [FT_W-1:0] diff;
    diff = a - b;
    return diff[FT_W-1];
  endfunction

endpackage

// File: rtl/wfq_free_slot_enc.sv
// Lowest-index free slot finder over the slot valid mask.
module wfq_free_slot_enc #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [DEPTH-1:0] valid_mask_i,
  output logic [IDX_W-1:0] free_idx_o,
  output logic             any_free_o
);

  // Walk downward so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_mask_i[i]) begin
        free_idx_o = IDX_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfq_tag_sorter.sv
// WFQ tag sorter: buffers tagged packets, finds the earliest finish time by a
// sequential scan, hands it to the link and reports the departure upstream.
module wfq_tag_sorter
  import wfq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tag_valid,
  input  logic [FT_W-1:0]  tag_ftime,
  input  logic [FID_W-1:0] tag_flow_id,
  input  logic [LEN_W-1:0] tag_length,
  output logic             full,
  output logic             overflow,
  output logic [IDX_W:0]   count,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [FT_W-1:0]  deq_ftime,
  output logic [FID_W-1:0] deq_flow_id,
  output logic [LEN_W-1:0] deq_length,
  output logic             depart,
  output logic [FID_W-1:0] depart_flow_id,
  output logic [LEN_W-1:0] depart_length,
  output logic [1:0]       dbg_state
);

  // Link handshake: deq_valid rises with stable deq_* and stays up with deq_*
  // frozen until deq_ready is seen high on a rising edge; that edge is the
  // transfer, and deq_valid drops on the next cycle.

  sort_state_e      state_q, state_d;
  tag_entry_t       slot_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] snap_q;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W-1:0] scan_idx_q;
  logic             best_found_q;
  logic [FT_W-1:0]  best_ft_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] win_idx_q;
  logic             deq_valid_q;
  tag_entry_t       deq_entry_q;
  logic             depart_q;
  logic [FID_W-1:0] depart_flow_q;
  logic [LEN_W-1:0] depart_len_q;
  logic             overflow_q;

  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic             full_w;
  logic             ins_fire;
  logic             accept;
  logic             scan_last;
  logic             cand_better;
  logic             nb_found;
  logic [IDX_W-1:0] nb_idx;
  logic [FT_W-1:0]  nb_ft;
  tag_entry_t       new_entry;

  wfq_free_slot_enc #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_free_enc (
    .valid_mask_i (valid_q),
    .free_idx_o   (free_idx),
    .any_free_o   (any_free)
  );

  assign full_w    = (count_q == (IDX_W+1)'(DEPTH));
  assign ins_fire  = tag_valid && !full_w && any_free;
  assign accept    = (state_q == ST_PRESENT) && deq_valid_q && deq_ready;
  assign scan_last = (scan_idx_q == IDX_W'(DEPTH - 1));
  assign new_entry = '{ftime: tag_ftime, flow_id: tag_flow_id, length: tag_length};

  // Strictly-earlier update keeps the lower slot on equal finish times.
  assign cand_better = snap_q[scan_idx_q] &&
                       (!best_found_q || ft_earlier(slot_q[scan_idx_q].ftime, best_ft_q));
  assign nb_found    = best_found_q || cand_better;
  assign nb_idx      = cand_better ? scan_idx_q : best_idx_q;
  assign nb_ft       = cand_better ? slot_q[scan_idx_q].ftime : best_ft_q;

  always_comb begin
    valid_d = valid_q;
    if (accept) valid_d[win_idx_q] = 1'b0;
    // Free slot comes from the pre-accept mask, so it never hits win_idx_q.
    if (ins_fire) valid_d[free_idx] = 1'b1;
  end

  assign count_d = count_q + (IDX_W+1)'(ins_fire) - (IDX_W+1)'(accept);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (count_q != '0) state_d = ST_SCAN;
      ST_SCAN:    if (scan_last) state_d = nb_found ? ST_PRESENT : ST_IDLE;
      ST_PRESENT: if (accept) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      valid_q       <= '0;
      snap_q        <= '0;
      count_q       <= '0;
      scan_idx_q    <= '0;
      best_found_q  <= 1'b0;
      best_ft_q     <= '0;
      best_idx_q    <= '0;
      win_idx_q     <= '0;
      deq_valid_q   <= 1'b0;
      deq_entry_q   <= '0;
      depart_q      <= 1'b0;
      depart_flow_q <= '0;
      depart_len_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      depart_q   <= 1'b0;
      overflow_q <= tag_valid && full_w;
      if (ins_fire) slot_q[free_idx] <= new_entry;

      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            snap_q       <= valid_q;
            scan_idx_q   <= '0;
            best_found_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          scan_idx_q   <= scan_idx_q + IDX_W'(1);
          best_found_q <= nb_found;
          best_idx_q   <= nb_idx;
          best_ft_q    <= nb_ft;
          if (scan_last && nb_found) begin
            deq_entry_q <= slot_q[nb_idx];
            win_idx_q   <= nb_idx;
            deq_valid_q <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (accept) begin
            deq_valid_q   <= 1'b0;
            depart_q      <= 1'b1;
            depart_flow_q <= deq_entry_q.flow_id;
            depart_len_q  <= deq_entry_q.length;
          end
        end
        default: ;
      endcase
    end
  end

  assign full           = full_w;
  assign overflow       = overflow_q;
  assign count          = count_q;
  assign deq_valid      = deq_valid_q;
  assign deq_ftime      = deq_entry_q.ftime;
  assign deq_flow_id    = deq_entry_q.flow_id;
  assign deq_length     = deq_entry_q.length;
  assign depart         = depart_q;
  assign depart_flow_id = depart_flow_q;
  assign depart_length  = depart_len_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_wfq_tag_sorter.sv
// Self-checking bench for wfq_tag_sorter: directed scenarios plus randomized
// traffic, with a slot-pool reference model feeding an expected-dequeue queue.
module tb_wfq_tag_sorter;
  import wfq_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int EW    = FT_W + FID_W + LEN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tag_valid = 1'b0;
  logic [FT_W-1:0]  tag_ftime = '0;
  logic [FID_W-1:0] tag_flow_id = '0;
  logic [LEN_W-1:0] tag_length = '0;
  logic             full;
  logic             overflow;
  logic [IDX_W:0]   count;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [FT_W-1:0]  deq_ftime;
  logic [FID_W-1:0] deq_flow_id;
  logic [LEN_W-1:0] deq_length;
  logic             depart;
  logic [FID_W-1:0] depart_flow_id;
  logic [LEN_W-1:0] depart_length;
  logic [1:0]       dbg_state;

  wfq_tag_sorter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .tag_valid      (tag_valid),
    .tag_ftime      (tag_ftime),
    .tag_flow_id    (tag_flow_id),
    .tag_length     (tag_length),
    .full           (full),
    .overflow       (overflow),
    .count          (count),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_ftime      (deq_ftime),
    .deq_flow_id    (deq_flow_id),
    .deq_length     (deq_length),
    .depart         (depart),
    .depart_flow_id (depart_flow_id),
    .depart_length  (depart_length),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] dep_exp;
  bit            dep_pend = 1'b0;

  // Reference model: a pool of DEPTH optional entries.
  bit               m_v   [DEPTH];
  logic [FT_W-1:0]  m_ft  [DEPTH];
  logic [FID_W-1:0] m_fid [DEPTH];
  logic [LEN_W-1:0] m_len [DEPTH];
  int               m_count = 0;
  int               m_cur   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_earlier(input logic [FT_W-1:0] a, input logic [FT_W-1:0] b);
    int d;
    d = (int'(a) - int'(b) + (1 << FT_W)) % (1 << FT_W);
    return d >= (1 << (FT_W - 1));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_count = 0;
  endfunction

  // Returns 1 when the tag is dropped because every slot is taken.
  function automatic bit model_add(input logic [FT_W-1:0] ft, input logic [FID_W-1:0] fid,
                                   input logic [LEN_W-1:0] len);
    if (m_count == DEPTH) return 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_v[i]) begin
        m_v[i] = 1'b1; m_ft[i] = ft; m_fid[i] = fid; m_len[i] = len;
        m_count++;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // The entry the next full scan must choose: earliest finish, lowest slot on ties.
  function automatic void model_schedule();
    int best;
    best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && (best < 0 || model_earlier(m_ft[i], m_ft[best]))) best = i;
    if (best >= 0) begin
      m_cur = best;
      exp_q.push_back({m_ft[best], m_fid[best], m_len[best]});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [FT_W-1:0] ft, input logic [FID_W-1:0] fid,
                        input logic [LEN_W-1:0] len);
    bit dropped;
    tag_ftime = ft; tag_flow_id = fid; tag_length = len; tag_valid = 1'b1;
    tick();
    tag_valid = 1'b0;
    dropped = model_add(ft, fid, len);
    check("insert_overflow", overflow, dropped);
    check("insert_count", count, m_count);
    check("insert_full", full, m_count == DEPTH);
  endtask

  task automatic insert_first(input logic [FT_W-1:0] ft, input logic [FID_W-1:0] fid,
                              input logic [LEN_W-1:0] len);
    insert(ft, fid, len);
    model_schedule();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!deq_valid && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    check("deq_valid_wait", deq_valid, 1'b1);
    ok = deq_valid;
  endtask

  task automatic do_accept(input bit with_ins, input logic [FT_W-1:0] ft,
                           input logic [FID_W-1:0] fid, input logic [LEN_W-1:0] len);
    bit ok;
    bit dropped;
    wait_valid(ok);
    if (!ok) return;
    deq_ready = 1'b1;
    if (with_ins) begin
      tag_ftime = ft; tag_flow_id = fid; tag_length = len; tag_valid = 1'b1;
    end
    tick();
    deq_ready = 1'b0;
    tag_valid = 1'b0;
    // Insert lands in the pre-accept free mask, then the winner is released.
    dropped = with_ins ? model_add(ft, fid, len) : 1'b0;
    m_v[m_cur] = 1'b0;
    m_count--;
    check("accept_count", count, m_count);
    check("accept_full", full, m_count == DEPTH);
    check("accept_overflow", overflow, dropped);
    if (m_count > 0) model_schedule();
  endtask

  function automatic logic [FT_W-1:0] rand_ft(input logic [FT_W-1:0] base);
    if ($urandom_range(0, 1) == 0) return base + FT_W'($urandom_range(0, 7));
    return base + FT_W'($urandom_range(0, 600));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      dep_pend = 1'b0;
    end else begin
      if (dep_pend) begin
        check("depart_pulse", depart, 1'b1);
        check("depart_flow_id", depart_flow_id, dep_exp[FID_W+LEN_W-1:LEN_W]);
        check("depart_length", depart_length, dep_exp[LEN_W-1:0]);
        dep_pend = 1'b0;
      end else if (depart) begin
        check("depart_spurious", depart, 1'b0);
      end
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          check("deq_unexpected", deq_valid, 1'b0);
        end else begin
          dep_exp = exp_q.pop_front();
          check("deq_ftime", deq_ftime, dep_exp[EW-1:FID_W+LEN_W]);
          check("deq_flow_id", deq_flow_id, dep_exp[FID_W+LEN_W-1:LEN_W]);
          check("deq_length", deq_length, dep_exp[LEN_W-1:0]);
          dep_pend = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int lat;
    logic [FT_W-1:0] base;

    model_clear();
    repeat (3) tick();
    check("reset_count", count, 0);
    check("reset_full", full, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_deq_valid", deq_valid, 1'b0);
    check("reset_depart", depart, 1'b0);
    check("reset_deq_ftime", deq_ftime, 0);
    check("reset_deq_flow_id", deq_flow_id, 0);
    check("reset_depart_length", depart_length, 0);
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    tick();

    // Single tag into an empty sorter: last SCAN edge is t+DEPTH+1, so the
    // link can first take it on edge t+DEPTH+2.
    insert_first(16'd77, 13'd5, 16'd100);
    lat = 0;
    while (!deq_valid && lat < 4 * DEPTH) begin
      tick();
      lat++;
    end
    check("latency_edges", lat + 1, DEPTH + 2);
    do_accept(1'b0, '0, '0, '0);
    repeat (2) tick();

    // Asynchronous reset in the middle of a scan.
    insert(16'd300, 13'd1, 16'd10);
    insert(16'd200, 13'd2, 16'd20);
    insert(16'd100, 13'd3, 16'd30);
    tick();
    check("midscan_state", dbg_state, ST_SCAN);
    #2 rst = 1'b0;
    #1;
    check("midscan_rst_count", count, 0);
    check("midscan_rst_deq_valid", deq_valid, 1'b0);
    check("midscan_rst_state", dbg_state, ST_IDLE);
    model_clear();
    exp_q.delete();
    tick();
    rst = 1'b1;
    repeat (DEPTH + 4) tick();
    check("midscan_post_deq_valid", deq_valid, 1'b0);
    check("midscan_post_count", count, 0);

    // Ordering: blocker presented first, then 10/20/30 by finish time.
    insert_first(16'd5, 13'd100, 16'd1);
    wait_valid(ok);
    insert(16'd30, 13'd2, 16'd12);
    insert(16'd10, 13'd1, 16'd8);
    insert(16'd20, 13'd3, 16'd16);
    repeat (4) do_accept(1'b0, '0, '0, '0);

    // Wrap-around: 0xFFF0 is earlier than 0x0005.
    insert_first(16'hFFE0, 13'd100, 16'd1);
    wait_valid(ok);
    insert(16'h0005, 13'd8, 16'd40);
    insert(16'hFFF0, 13'd7, 16'd44);
    repeat (3) do_accept(1'b0, '0, '0, '0);

    // Equal finish times: lower slot wins.
    insert_first(16'd2, 13'd100, 16'd1);
    wait_valid(ok);
    insert(16'd40, 13'd10, 16'd50);
    insert(16'd40, 13'd11, 16'd60);
    repeat (3) do_accept(1'b0, '0, '0, '0);

    // Back-pressure: presented entry stays frozen while a smaller tag arrives.
    insert_first(16'd500, 13'd20, 16'd64);
    wait_valid(ok);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) insert(16'd100, 13'd21, 16'd32);
      else tick();
      check("hold_deq_valid", deq_valid, 1'b1);
      check("hold_deq_ftime", deq_ftime, m_ft[m_cur]);
      check("hold_deq_flow_id", deq_flow_id, m_fid[m_cur]);
      check("hold_deq_length", deq_length, m_len[m_cur]);
    end
    repeat (2) do_accept(1'b0, '0, '0, '0);

    // Fill, overflow, then accept with and without a same-edge insert.
    insert_first(16'd1000, 13'd200, 16'd9);
    wait_valid(ok);
    for (int i = 1; i < DEPTH; i++) insert(FT_W'(1000 + (i * 37) % 211), FID_W'(200 + i), LEN_W'(i));
    insert(16'd900, 13'd999, 16'd99);
    tick();
    check("overflow_single_pulse", overflow, 1'b0);
    check("overflow_count_held", count, DEPTH);
    do_accept(1'b0, '0, '0, '0);
    do_accept(1'b1, 16'd1100, 13'd300, 16'd77);
    for (int i = 0; i < DEPTH + 2 && m_count > 0; i++) do_accept(1'b0, '0, '0, '0);

    // Randomized traffic around a base that often wraps.
    base = FT_W'(16'hFF00 + $urandom_range(0, 255));
    for (int r = 0; r < 30; r++) begin
      int k;
      if (m_count == 0) insert_first(rand_ft(base), FID_W'($urandom), LEN_W'($urandom));
      wait_valid(ok);
      if (!ok) break;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) insert(rand_ft(base), FID_W'($urandom), LEN_W'($urandom));
      do_accept($urandom_range(0, 3) == 0, rand_ft(base), FID_W'($urandom), LEN_W'($urandom));
    end
    for (int i = 0; i < DEPTH + 4 && m_count > 0; i++) do_accept(1'b0, '0, '0, '0);

    repeat (4) tick();
    check("final_count", count, 0);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_deq_valid", deq_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
